// File: rtl/tcore_param.sv
// Shared core types for the branch resolution path: prediction record,
// resolver FSM states, default in-flight depth and the hit rule.
package tcore_param;

  localparam int BRU_DEPTH = 4;

  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
  } predict_info_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } resolve_state_e;

  // A prediction is correct when the direction matches and, for a taken
  // branch, the predicted target matches the resolved target.
  function automatic logic bru_hit(input predict_info_t pred,
                                   input logic          taken,
                                   input logic [31:0]   target);
    return (pred.taken == taken) && (!taken || (pred.pc == target));
  endfunction

endpackage

// File: rtl/spec_fifo.sv
// In-order store of in-flight predictions. Clear has priority over push and
// pop so a flush empties the queue in one edge.
module spec_fifo
  import tcore_param::*;
#(
  parameter  int DEPTH = BRU_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  predict_info_t data_i,
  input  logic          pop_i,
  output predict_info_t head_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  predict_info_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = push_i && !clear_i && (r_count != FULL);
  assign w_do_pop  = pop_i  && !clear_i && (r_count != '0);
  assign head_o    = r_mem[r_rd_ptr];
  assign count_o   = r_count;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst_i || clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Record storage.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; entries are only read once the count
    // marks them valid, so clearing them would cost flops for nothing.
    if (w_do_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares each resolved control-flow instruction against the oldest
// in-flight prediction, reports hit/type to the predictor and, on a miss,
// flushes the queue and holds a corrected fetch PC until fetch accepts it.
module branch_resolve_unit
  import tcore_param::*;
#(
  parameter int DEPTH = BRU_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   spec_valid_i,
  input  predict_info_t          spec_i,
  output logic                   spec_ready_o,
  input  logic                   ex_valid_i,
  input  logic                   ex_branch_i,
  input  logic                   ex_taken_i,
  input  logic [31:0]            ex_target_i,
  input  logic [31:0]            ex_next_pc_i,
  output logic                   spec_hit_o,
  output logic                   branch_type_o,
  output logic                   flush_o,
  output logic                   redirect_valid_o,
  output logic [31:0]            redirect_pc_o,
  input  logic                   redirect_ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   err_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  resolve_state_e r_state;
  logic           r_spec_hit;
  logic           r_branch_type;
  logic           r_flush;
  logic           r_err;
  logic [31:0]    r_redirect_pc;

  predict_info_t  w_head;
  logic [CW-1:0]  w_count;
  logic           w_idle;
  logic           w_pop;
  logic           w_underflow;
  logic           w_hit;
  logic           w_miss_pop;
  logic           w_push;

  // Readiness uses the registered count only: a same-cycle pop never frees
  // a slot for a push.
  assign w_idle       = (r_state == IDLE);
  assign spec_ready_o = w_idle && (w_count < CW'(DEPTH));
  assign w_pop        = ex_valid_i && w_idle && (w_count != '0);
  assign w_underflow  = ex_valid_i && w_idle && (w_count == '0);
  assign w_hit        = bru_hit(w_head, ex_taken_i, ex_target_i);
  assign w_miss_pop   = w_pop && !w_hit;
  // A push alongside a miss belongs to the wrong path and is dropped.
  assign w_push       = spec_valid_i && spec_ready_o && !w_miss_pop;

  spec_fifo #(
    .DEPTH (DEPTH)
  ) u_spec_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_ni),
    .clear_i (w_miss_pop),
    .push_i  (w_push),
    .data_i  (spec_i),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .count_o (w_count)
  );

  // Resolver FSM: a miss holds the unit in REDIRECT until fetch takes the PC.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:     if (w_miss_pop)       r_state <= REDIRECT;
        REDIRECT: if (redirect_ready_i) r_state <= IDLE;
        default:                        r_state <= IDLE;
      endcase
    end
  end

  // Predictor feedback, flush pulse, corrected PC and sticky underflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      r_spec_hit    <= 1'b0;
      r_branch_type <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_err         <= 1'b0;
    end else begin
      r_spec_hit    <= w_pop && w_hit;
      r_branch_type <= w_pop && ex_branch_i;
      r_flush       <= w_miss_pop;
      if (w_miss_pop) r_redirect_pc <= ex_taken_i ? ex_target_i : ex_next_pc_i;
      if (w_underflow) r_err <= 1'b1;
    end
  end

  assign spec_hit_o       = r_spec_hit;
  assign branch_type_o    = r_branch_type;
  assign flush_o          = r_flush;
  assign redirect_valid_o = (r_state == REDIRECT);
  assign redirect_pc_o    = r_redirect_pc;
  assign count_o          = w_count;
  assign err_o            = r_err;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_branch_resolve_unit;
  import tcore_param::*;

  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          spec_valid_i;
  predict_info_t spec_i;
  logic          spec_ready_o;
  logic          ex_valid_i;
  logic          ex_branch_i;
  logic          ex_taken_i;
  logic [31:0]   ex_target_i;
  logic [31:0]   ex_next_pc_i;
  logic          spec_hit_o;
  logic          branch_type_o;
  logic          flush_o;
  logic          redirect_valid_o;
  logic [31:0]   redirect_pc_o;
  logic          redirect_ready_i;
  logic [2:0]    count_o;
  logic          err_o;

  int n_checks = 0;
  int n_errors = 0;

  branch_resolve_unit #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .spec_valid_i     (spec_valid_i),
    .spec_i           (spec_i),
    .spec_ready_o     (spec_ready_o),
    .ex_valid_i       (ex_valid_i),
    .ex_branch_i      (ex_branch_i),
    .ex_taken_i       (ex_taken_i),
    .ex_target_i      (ex_target_i),
    .ex_next_pc_i     (ex_next_pc_i),
    .spec_hit_o       (spec_hit_o),
    .branch_type_o    (branch_type_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .count_o          (count_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    spec_valid_i     = 1'b0;
    spec_i           = '0;
    ex_valid_i       = 1'b0;
    ex_branch_i      = 1'b0;
    ex_taken_i       = 1'b0;
    ex_target_i      = '0;
    ex_next_pc_i     = '0;
    redirect_ready_i = 1'b0;
  endtask

  task automatic push(input logic taken, input logic [31:0] pc);
    spec_valid_i = 1'b1;
    spec_i       = '{taken: taken, pc: pc};
    tick();
    spec_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b1;
    tick();
    rst_ni = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    n_checks++; if (count_o !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_checks++; if (spec_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", spec_ready_o); end
    n_checks++; if ({spec_hit_o, branch_type_o, flush_o, redirect_valid_o, err_o} !== 5'b0)
      begin n_errors++; $display("FAIL reset_flags: got %b want 00000", {spec_hit_o, branch_type_o, flush_o, redirect_valid_o, err_o}); end
    n_checks++; if (redirect_pc_o !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h want 0", redirect_pc_o); end
  endtask

  task automatic test_hit();
    push(1'b1, 32'h100);
    n_checks++; if (count_o !== 3'd1) begin n_errors++; $display("FAIL hit_count_push: got %0d want 1", count_o); end
    ex_valid_i = 1'b1; ex_branch_i = 1'b1; ex_taken_i = 1'b1; ex_target_i = 32'h100; ex_next_pc_i = 32'h104;
    tick();
    idle_inputs();
    n_checks++; if (spec_hit_o !== 1'b1) begin n_errors++; $display("FAIL hit_spec_hit: got %b want 1", spec_hit_o); end
    n_checks++; if (branch_type_o !== 1'b1) begin n_errors++; $display("FAIL hit_branch_type: got %b want 1", branch_type_o); end
    n_checks++; if (flush_o !== 1'b0 || redirect_valid_o !== 1'b0)
      begin n_errors++; $display("FAIL hit_no_flush: got flush=%b rv=%b want 0 0", flush_o, redirect_valid_o); end
    n_checks++; if (count_o !== 3'd0) begin n_errors++; $display("FAIL hit_count_pop: got %0d want 0", count_o); end
    tick();
    n_checks++; if (spec_hit_o !== 1'b0 || branch_type_o !== 1'b0)
      begin n_errors++; $display("FAIL hit_pulse_clear: got %b%b want 00", spec_hit_o, branch_type_o); end
  endtask

  task automatic test_miss_taken();
    push(1'b0, 32'h200);
    ex_valid_i = 1'b1; ex_branch_i = 1'b1; ex_taken_i = 1'b1; ex_target_i = 32'h300; ex_next_pc_i = 32'h204;
    tick();
    n_checks++; if (flush_o !== 1'b1) begin n_errors++; $display("FAIL missT_flush: got %b want 1", flush_o); end
    n_checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h300)
      begin n_errors++; $display("FAIL missT_redirect: got rv=%b pc=%h want 1 300", redirect_valid_o, redirect_pc_o); end
    n_checks++; if (count_o !== 3'd0 || spec_hit_o !== 1'b0)
      begin n_errors++; $display("FAIL missT_count_hit: got cnt=%0d hit=%b want 0 0", count_o, spec_hit_o); end
    n_checks++; if (spec_ready_o !== 1'b0) begin n_errors++; $display("FAIL missT_ready: got %b want 0", spec_ready_o); end
    // Stimulus during REDIRECT must be ignored (no underflow, no push).
    ex_target_i = 32'h999; spec_valid_i = 1'b1; spec_i = '{taken: 1'b1, pc: 32'h888};
    tick();
    tick();
    n_checks++; if (flush_o !== 1'b0) begin n_errors++; $display("FAIL missT_flush_once: got %b want 0", flush_o); end
    n_checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h300)
      begin n_errors++; $display("FAIL missT_hold: got rv=%b pc=%h want 1 300", redirect_valid_o, redirect_pc_o); end
    n_checks++; if (err_o !== 1'b0 || count_o !== 3'd0)
      begin n_errors++; $display("FAIL missT_ignored: got err=%b cnt=%0d want 0 0", err_o, count_o); end
    idle_inputs();
    redirect_ready_i = 1'b1;
    tick();
    redirect_ready_i = 1'b0;
    n_checks++; if (redirect_valid_o !== 1'b0 || spec_ready_o !== 1'b1)
      begin n_errors++; $display("FAIL missT_release: got rv=%b rdy=%b want 0 1", redirect_valid_o, spec_ready_o); end
  endtask

  task automatic test_miss_not_taken();
    push(1'b1, 32'h400);
    ex_valid_i = 1'b1; ex_branch_i = 1'b1; ex_taken_i = 1'b0; ex_target_i = 32'h400; ex_next_pc_i = 32'h1004;
    tick();
    idle_inputs();
    n_checks++; if (redirect_pc_o !== 32'h1004) begin n_errors++; $display("FAIL missN_pc: got %h want 1004", redirect_pc_o); end
    n_checks++; if (spec_hit_o !== 1'b0 || branch_type_o !== 1'b1)
      begin n_errors++; $display("FAIL missN_feedback: got hit=%b bt=%b want 0 1", spec_hit_o, branch_type_o); end
    n_checks++; if (flush_o !== 1'b1) begin n_errors++; $display("FAIL missN_flush: got %b want 1", flush_o); end
    redirect_ready_i = 1'b1;
    tick();
    redirect_ready_i = 1'b0;
    n_checks++; if (redirect_valid_o !== 1'b0) begin n_errors++; $display("FAIL missN_release: got %b want 0", redirect_valid_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 32'h500 + 32'(i * 4));
      n_checks++; if (count_o !== 3'((i < 4) ? i + 1 : 4))
        begin n_errors++; $display("FAIL full_count_%0d: got %0d want %0d", i, count_o, (i < 4) ? i + 1 : 4); end
      n_checks++; if (spec_ready_o !== ((i + 1) < 4))
        begin n_errors++; $display("FAIL full_ready_%0d: got %b want %b", i, spec_ready_o, (i + 1) < 4); end
    end
    // Push and pop together at full: the push must be refused.
    spec_valid_i = 1'b1; spec_i = '{taken: 1'b1, pc: 32'h600};
    ex_valid_i = 1'b1; ex_branch_i = 1'b1; ex_taken_i = 1'b1; ex_target_i = 32'h500;
    tick();
    idle_inputs();
    n_checks++; if (count_o !== 3'd3 || spec_hit_o !== 1'b1)
      begin n_errors++; $display("FAIL full_pushpop: got cnt=%0d hit=%b want 3 1", count_o, spec_hit_o); end
    for (int i = 1; i < 4; i++) begin
      ex_valid_i = 1'b1; ex_branch_i = 1'b0; ex_taken_i = 1'b1; ex_target_i = 32'h500 + 32'(i * 4);
      tick();
      idle_inputs();
      n_checks++; if (spec_hit_o !== 1'b1 || branch_type_o !== 1'b0 || count_o !== 3'(3 - i))
        begin n_errors++; $display("FAIL full_drain_%0d: got hit=%b bt=%b cnt=%0d want 1 0 %0d", i, spec_hit_o, branch_type_o, count_o, 3 - i); end
    end
  endtask

  task automatic test_underflow();
    ex_valid_i = 1'b1; ex_branch_i = 1'b1; ex_taken_i = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (err_o !== 1'b1 || count_o !== 3'd0)
      begin n_errors++; $display("FAIL under_err: got err=%b cnt=%0d want 1 0", err_o, count_o); end
    n_checks++; if (spec_hit_o !== 1'b0 || branch_type_o !== 1'b0)
      begin n_errors++; $display("FAIL under_feedback: got %b%b want 00", spec_hit_o, branch_type_o); end
    tick();
    tick();
    n_checks++; if (err_o !== 1'b1) begin n_errors++; $display("FAIL under_sticky: got %b want 1", err_o); end
    do_reset();
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL under_reset: got %b want 0", err_o); end
  endtask

  task automatic test_reset_mid_redirect();
    push(1'b1, 32'h700);
    ex_valid_i = 1'b1; ex_taken_i = 1'b1; ex_target_i = 32'h704;
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (redirect_valid_o !== 1'b1)
        begin n_errors++; $display("FAIL rstmid_hold_%0d: got %b want 1", i, redirect_valid_o); end
      tick();
    end
    do_reset();
    n_checks++; if (redirect_valid_o !== 1'b0 || spec_ready_o !== 1'b1 || redirect_pc_o !== 32'h0)
      begin n_errors++; $display("FAIL rstmid_drop: got rv=%b rdy=%b pc=%h want 0 1 0", redirect_valid_o, spec_ready_o, redirect_pc_o); end
  endtask

  // Randomized traffic against a transaction-level model built on a queue.
  task automatic test_random();
    predict_info_t q[$];
    predict_info_t head;
    bit            m_redir, m_err, e_hit, e_bt, e_flush, miss, accept, rst;
    logic [31:0]   m_pc;
    idle_inputs();
    do_reset();
    m_redir = 0; m_err = 0; m_pc = '0; e_hit = 0; e_bt = 0; e_flush = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst              = ($urandom_range(0, 99) == 0);
      rst_ni           = rst;
      spec_valid_i     = $urandom_range(0, 1);
      spec_i           = '{taken: 1'($urandom_range(0, 1)), pc: 32'h1000 + 32'($urandom_range(0, 3) * 4)};
      ex_valid_i       = ($urandom_range(0, 9) < 4);
      ex_branch_i      = $urandom_range(0, 1);
      ex_taken_i       = $urandom_range(0, 1);
      ex_target_i      = 32'h1000 + 32'($urandom_range(0, 3) * 4);
      ex_next_pc_i     = $urandom;
      redirect_ready_i = ($urandom_range(0, 9) < 3);

      accept = !m_redir && (q.size() < DEPTH);
      n_checks++; if (spec_ready_o !== accept)
        begin n_errors++; $display("FAIL rand_ready c%0d: got %b want %b", cyc, spec_ready_o, accept); end

      e_hit = 0; e_bt = 0; e_flush = 0; miss = 0;
      if (rst) begin
        q.delete(); m_redir = 0; m_err = 0; m_pc = '0;
      end else if (m_redir) begin
        if (redirect_ready_i) m_redir = 0;
      end else begin
        if (ex_valid_i) begin
          if (q.size() == 0) m_err = 1;
          else begin
            head  = q.pop_front();
            e_hit = (head.taken == ex_taken_i) && (!ex_taken_i || head.pc == ex_target_i);
            e_bt  = ex_branch_i;
            if (!e_hit) begin
              miss = 1;
              m_pc = ex_taken_i ? ex_target_i : ex_next_pc_i;
            end
          end
        end
        if (miss) begin
          q.delete(); m_redir = 1; e_flush = 1;
        end else if (spec_valid_i && accept) begin
          q.push_back(spec_i);
        end
      end

      tick();
      rst_ni = 1'b0;
      n_checks++; if (count_o !== 3'(q.size()))
        begin n_errors++; $display("FAIL rand_count c%0d: got %0d want %0d", cyc, count_o, q.size()); end
      n_checks++; if (spec_hit_o !== e_hit || branch_type_o !== e_bt)
        begin n_errors++; $display("FAIL rand_feedback c%0d: got hit=%b bt=%b want %b %b", cyc, spec_hit_o, branch_type_o, e_hit, e_bt); end
      n_checks++; if (flush_o !== e_flush)
        begin n_errors++; $display("FAIL rand_flush c%0d: got %b want %b", cyc, flush_o, e_flush); end
      n_checks++; if (redirect_valid_o !== m_redir || redirect_pc_o !== m_pc)
        begin n_errors++; $display("FAIL rand_redirect c%0d: got rv=%b pc=%h want %b %h", cyc, redirect_valid_o, redirect_pc_o, m_redir, m_pc); end
      n_checks++; if (err_o !== m_err)
        begin n_errors++; $display("FAIL rand_err c%0d: got %b want %b", cyc, err_o, m_err); end
    end
    idle_inputs();
  endtask

  initial begin
    rst_ni = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_hit();
    test_miss_taken();
    test_miss_not_taken();
    test_full();
    test_underflow();
    test_reset_mid_redirect();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
